// File: rtl/iter_divider.sv
// Radix-2 restoring divider for EXE DIV/DIVU: quotient, remainder, signed or unsigned; fixed WIDTH+1 cycle latency.
// Results held in DONE until div_ack or div_begin drops; dropping div_begin mid-divide aborts without div_end.
module iter_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             div_begin,
   input  logic             div_sign,
   input  logic [WIDTH-1:0] div_op1,
   input  logic [WIDTH-1:0] div_op2,
   input  logic             div_ack,
   output logic [WIDTH-1:0] div_result,
   output logic [WIDTH-1:0] div_remainder,
   output logic             div_end,
   output logic             div_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               sign_q, sign_d;
   logic               neg1_q, neg1_d;
   logic               neg2_q, neg2_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hold_res_q, hold_res_d;
   logic [WIDTH-1:0]   hold_rem_q, hold_rem_d;

   logic               op1_neg, op2_neg;
   logic [WIDTH-1:0]   op1_mag, op2_mag;
   logic [WIDTH:0]     trial;
   logic               last_step;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign op1_neg   = div_sign & div_op1[WIDTH-1];
   assign op2_neg   = div_sign & div_op2[WIDTH-1];
   assign op1_mag   = op1_neg ? -div_op1 : div_op1;
   assign op2_mag   = op2_neg ? -div_op2 : div_op2;
   assign trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
   assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

   // A zero divisor leaves |op1| in the remainder, so the normal dividend-sign
   // correction restores the original op1; only the quotient needs forcing.
   assign quo_fix = dz_q ? '1 : ((neg1_q ^ neg2_q) ? -quo_q : quo_q);
   assign rem_fix = neg1_q ? -rem_q : rem_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (div_begin) state_d = S_BUSY;
         S_BUSY: begin
            if (!div_begin)    state_d = S_IDLE;
            else if (last_step) state_d = S_DONE;
         end
         S_DONE: if (div_ack || !div_begin) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      div_end       = (state_q == S_DONE);
      div_busy      = (state_q == S_BUSY);
      div_result    = (state_q == S_DONE) ? quo_fix : hold_res_q;
      div_remainder = (state_q == S_DONE) ? rem_fix : hold_rem_q;
   end

   always_comb begin
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvs_d      = dvs_q;
      sign_d     = sign_q;
      neg1_d     = neg1_q;
      neg2_d     = neg2_q;
      dz_d       = dz_q;
      hold_res_d = hold_res_q;
      hold_rem_d = hold_rem_q;
      case (state_q)
         S_IDLE: begin
            if (div_begin) begin
               sign_d = div_sign;
               neg1_d = op1_neg;
               neg2_d = op2_neg;
               dz_d   = (div_op2 == '0);
               rem_d  = '0;
               quo_d  = op1_mag;
               dvs_d  = op2_mag;
               cnt_d  = '0;
            end
         end
         S_BUSY: begin
            if (div_begin) begin
               if (!trial[WIDTH]) begin
                  rem_d = trial[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            // Snapshot so the outputs keep their value once DONE is left.
            hold_res_d = quo_fix;
            hold_rem_d = rem_fix;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         sign_q     <= 1'b0;
         neg1_q     <= 1'b0;
         neg2_q     <= 1'b0;
         dz_q       <= 1'b0;
         hold_res_q <= '0;
         hold_rem_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         sign_q     <= sign_d;
         neg1_q     <= neg1_d;
         neg2_q     <= neg2_d;
         dz_q       <= dz_d;
         hold_res_q <= hold_res_d;
         hold_rem_q <= hold_rem_d;
      end
   end

endmodule
